// File: rtl/conv_mem_responder.sv
// conv_mem_responder
// Scratchpad memory responder for the accelerator memory port. A compute
// initiator issues word reads/writes (mem_operation 01 = read, 11 = write) and
// receives a one-cycle mem_opdone pulse after LATENCY wait cycles. A host port
// shares the same scratchpad and is served only while the initiator is quiet.
// Accesses at or above DEPTH complete normally, but reads return zero, writes
// are dropped, and the sticky err flag is set.

module conv_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    // initiator port
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  mem_operation,
    output logic [31:0] data_o,
    output logic        mem_opdone,
    // host port
    input  logic        host_req,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_ack,
    // status
    output logic        err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    // Last value of the wait counter before the transaction completes.
    localparam logic [3:0]  LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;

    // Request captured on acceptance; the initiator holds it, but only the
    // latched copy is trusted while waiting.
    logic [31:0] op_addr;
    logic [31:0] op_data;
    logic        op_is_write;

    logic [31:0] mem [DEPTH];

    // Combinational decode of the current cycle.
    logic          req_valid;
    logic          commit;
    logic [31:0]   c_addr;
    logic [31:0]   c_data;
    logic          c_write;
    logic          c_in_range;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_rd;
    logic          host_fire;
    logic          h_in_range;
    logic [AW-1:0] h_idx;
    logic [31:0]   h_rd;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    // Decode the commit/host-service conditions and the shared write port.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        req_valid  = mem_operation[0];

        // With LATENCY=0 the transaction commits straight from IDLE using the
        // live inputs; otherwise it commits from WAIT using the latched copy.
        c_addr     = (state == ST_WAIT) ? op_addr     : addr_i;
        c_data     = (state == ST_WAIT) ? op_data     : data_i;
        c_write    = (state == ST_WAIT) ? op_is_write : mem_operation[1];
        c_in_range = (c_addr < DEPTH_W);
        c_idx      = c_addr[AW-1:0];
        c_rd       = c_in_range ? mem[c_idx] : 32'h0;

        commit     = 1'b0;
        if (state == ST_IDLE && req_valid && LATENCY == 0) begin
            commit = 1'b1;
        end else if (state == ST_WAIT && req_valid && wait_cnt == LAST_WAIT) begin
            commit = 1'b1;
        end

        // Host is served only in IDLE with no initiator request, and never in
        // the cycle its previous ack is showing (host_req is still high then).
        host_fire  = (state == ST_IDLE) && !req_valid && host_req && !host_ack;
        h_in_range = (host_addr < DEPTH_W);
        h_idx      = host_addr[AW-1:0];
        h_rd       = h_in_range ? mem[h_idx] : 32'h0;

        mem_we     = 1'b0;
        mem_waddr  = h_idx;
        mem_wdata  = host_wdata;
        if (commit && c_write && c_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = c_idx;
            mem_wdata = c_data;
        end else if (host_fire && host_we && h_in_range) begin
            mem_we    = 1'b1;
        end
        // Nothing may land in the array while reset is held.
        mem_we     = mem_we && reset_n;
    end

    // Scratchpad write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; its contents are undefined after power-up, which keeps it mappable onto RAM.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Transaction FSM with registered completion, read data and error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            op_addr     <= 32'h0;
            op_data     <= 32'h0;
            op_is_write <= 1'b0;
            data_o      <= 32'h0;
            mem_opdone  <= 1'b0;
            host_rdata  <= 32'h0;
            host_ack    <= 1'b0;
            err         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register updates from the same pre-edge values.
            mem_opdone <= 1'b0;
            host_ack   <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_addr     <= addr_i;
                        op_data     <= data_i;
                        op_is_write <= mem_operation[1];
                        wait_cnt    <= 4'd0;
                        state       <= (LATENCY == 0) ? ST_ACK : ST_WAIT;
                    end else if (host_fire) begin
                        host_ack <= 1'b1;
                        if (!host_we) begin
                            host_rdata <= h_rd;
                        end
                        if (!h_in_range) begin
                            err <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!req_valid) begin
                        // Initiator withdrew: abandon without completing.
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state    <= ST_ACK;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                ST_ACK: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // The edge entering ACK completes the initiator transaction.
            if (commit) begin
                mem_opdone <= 1'b1;
                if (!c_write) begin
                    data_o <= c_rd;
                end
                if (!c_in_range) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mem_responder.sv
// Testbench for conv_mem_responder: a directed vector table, hand-written
// multi-cycle sequences (streaming, contention, reset mid-wait, LATENCY=0
// build) and a randomized phase checked against an array-based memory model.

module tb_conv_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 1;

    logic        clk;
    logic        reset_n;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [1:0]  mem_operation;
    logic [31:0] data_o;
    logic        mem_opdone;
    logic        host_req;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic        err;

    // LATENCY=0 instance signals
    logic [31:0] a0_addr;
    logic [31:0] a0_data;
    logic [1:0]  a0_op;
    logic [31:0] a0_dout;
    logic        a0_done;
    logic [31:0] a0_hrdata;
    logic        a0_hack;
    logic        a0_err;

    int total = 0;
    int bad   = 0;

    // Reference model: plain word array plus sticky error bit.
    logic [31:0] model_mem [DEPTH];
    bit          model_err;

    typedef struct {
        bit          host;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [15];

    conv_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .mem_operation (mem_operation),
        .data_o        (data_o),
        .mem_opdone    (mem_opdone),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_rdata    (host_rdata),
        .host_ack      (host_ack),
        .err           (err)
    );

    conv_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .addr_i        (a0_addr),
        .data_i        (a0_data),
        .mem_operation (a0_op),
        .data_o        (a0_dout),
        .mem_opdone    (a0_done),
        .host_req      (1'b0),
        .host_we       (1'b0),
        .host_addr     (32'h0),
        .host_wdata    (32'h0),
        .host_rdata    (a0_hrdata),
        .host_ack      (a0_hack),
        .err           (a0_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input bit we, input logic [31:0] a, input logic [31:0] d);
        if (a >= DEPTH) model_err = 1'b1;
        else if (we) model_mem[a] = d;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return (a >= DEPTH) ? 32'h0 : model_mem[a];
    endfunction

    // Initiator transaction: drive, wait for opdone (bounded), then release.
    task automatic init_xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd);
        int cyc = 0;
        bit got = 0;
        addr_i        = a;
        data_i        = d;
        mem_operation = we ? 2'b11 : 2'b01;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (mem_opdone) got = 1;
        end
        if (!got) check("init_timeout", 32'd0, 32'd1);
        else      check("init_latency", cyc, LAT + 1);
        rd            = data_o;
        mem_operation = 2'b00;
        tick();
        check("init_single_pulse", {31'b0, mem_opdone}, 32'd0);
    endtask

    // Host transaction: hold host_req until host_ack (bounded), then release.
    task automatic host_xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd);
        int cyc = 0;
        bit got = 0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (host_ack) got = 1;
        end
        if (!got) check("host_timeout", 32'd0, 32'd1);
        else      check("host_latency", cyc, 32'd1);
        rd       = host_rdata;
        host_req = 1'b0;
        tick();
        check("host_single_ack", {31'b0, host_ack}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          idx;
        int          last;
        int          done_cyc;
        int          ack_cyc;
        bit          seen;

        vecs[0]  = '{1, 1, 32'd0,          32'd5,          32'h0,          0};
        vecs[1]  = '{1, 1, 32'd1,          32'd4,          32'h0,          0};
        vecs[2]  = '{1, 1, 32'd2,          32'd3,          32'h0,          0};
        vecs[3]  = '{1, 1, 32'd3,          32'd3,          32'h0,          0};
        vecs[4]  = '{0, 0, 32'd2,          32'h0,          32'd3,          0};
        vecs[5]  = '{0, 1, 32'd40,         32'hCAFE_0001,  32'h0,          0};
        vecs[6]  = '{1, 0, 32'd40,         32'h0,          32'hCAFE_0001,  0};
        vecs[7]  = '{1, 1, 32'd255,        32'h1234_5678,  32'h0,          0};
        vecs[8]  = '{0, 0, 32'd255,        32'h0,          32'h1234_5678,  0};
        vecs[9]  = '{0, 0, 32'd256,        32'h0,          32'h0,          1};
        vecs[10] = '{0, 1, 32'd256,        32'hDEAD_BEEF,  32'h0,          1};
        vecs[11] = '{1, 0, 32'd0,          32'h0,          32'd5,          1};
        vecs[12] = '{1, 1, 32'h1000_0000, 32'd77,         32'h0,          1};
        vecs[13] = '{0, 0, 32'd0,          32'h0,          32'd5,          1};
        vecs[14] = '{1, 0, 32'd300,        32'h0,          32'h0,          1};

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_err = 1'b0;

        reset_n       = 1'b1;
        addr_i        = 32'h0;
        data_i        = 32'h0;
        mem_operation = 2'b00;
        host_req      = 1'b0;
        host_we       = 1'b0;
        host_addr     = 32'h0;
        host_wdata    = 32'h0;
        a0_addr       = 32'h0;
        a0_data       = 32'h0;
        a0_op         = 2'b00;

        // Reset state
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_o",     data_o,               32'h0);
        check("rst_opdone",     {31'b0, mem_opdone},  32'h0);
        check("rst_host_rdata", host_rdata,           32'h0);
        check("rst_host_ack",   {31'b0, host_ack},    32'h0);
        check("rst_err",        {31'b0, err},         32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].host) host_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            else              init_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata);
        end

        // Streaming reads: op held at read, address stepped after each opdone
        addr_i        = 32'd0;
        mem_operation = 2'b01;
        idx  = 0;
        cyc  = 0;
        last = 0;
        while (idx < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (mem_opdone) begin
                check($sformatf("stream_rd%0d", idx), data_o, model_read(idx));
                if (idx == 0) check("stream_first_lat", cyc, LAT + 1);
                else          check($sformatf("stream_gap%0d", idx), cyc - last, LAT + 2);
                last = cyc;
                idx++;
                addr_i = idx;
            end
        end
        if (idx < 4) check("stream_timeout", idx, 32'd4);
        mem_operation = 2'b00;
        tick();
        check("stream_no_extra", {31'b0, mem_opdone}, 32'd0);
        tick();

        // Host and initiator request in the same IDLE cycle
        host_req      = 1'b1;
        host_we       = 1'b0;
        host_addr     = 32'd0;
        addr_i        = 32'd1;
        mem_operation = 2'b01;
        cyc      = 0;
        done_cyc = 0;
        ack_cyc  = 0;
        while (ack_cyc == 0 && cyc < 40) begin
            tick();
            cyc++;
            if (mem_opdone) begin
                done_cyc = cyc;
                check("contend_rd", data_o, model_read(1));
                mem_operation = 2'b00;
            end
            if (host_ack) ack_cyc = cyc;
        end
        check("contend_opdone_cyc", done_cyc, LAT + 1);
        check("contend_ack_cyc",    ack_cyc,  LAT + 3);
        check("contend_host_rd",    host_rdata, model_read(0));
        host_req = 1'b0;
        tick();

        // Reset asserted while a write is waiting
        addr_i        = 32'd2;
        data_i        = 32'h0BAD_0BAD;
        mem_operation = 2'b11;
        tick();
        #1 reset_n = 1'b0;
        #1;
        check("midrst_data_o",     data_o,              32'h0);
        check("midrst_opdone",     {31'b0, mem_opdone}, 32'h0);
        check("midrst_host_rdata", host_rdata,          32'h0);
        check("midrst_err",        {31'b0, err},        32'h0);
        mem_operation = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        model_err = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_opdone) seen = 1;
        end
        check("midrst_no_opdone", {31'b0, seen}, 32'd0);
        host_xfer(1'b0, 32'd2, 32'h0, rd);
        check("midrst_word_kept", rd, model_read(2));

        // LATENCY=0 build: opdone in cycle 1
        a0_addr = 32'd7;
        a0_data = 32'h55AA_33CC;
        a0_op   = 2'b11;
        tick();
        check("l0_wr_done", {31'b0, a0_done}, 32'd1);
        a0_op = 2'b00;
        tick();
        check("l0_wr_single", {31'b0, a0_done}, 32'd0);
        a0_op = 2'b01;
        tick();
        check("l0_rd_done", {31'b0, a0_done}, 32'd1);
        check("l0_rd_data", a0_dout, 32'h55AA_33CC);
        a0_op = 2'b00;
        tick();
        check("l0_rd_single", {31'b0, a0_done}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 64; i++) begin
            logic [31:0] d;
            d = $urandom;
            host_xfer(1'b1, i, d, rd);
            model_apply(1'b1, i, d);
        end
        for (int i = 0; i < 150; i++) begin
            bit          use_host;
            bit          we;
            logic [31:0] a;
            logic [31:0] d;
            use_host = $urandom_range(0, 1);
            we       = $urandom_range(0, 1);
            a        = ($urandom_range(0, 7) == 0) ? 32'(256 + $urandom_range(0, 1000))
                                                   : 32'($urandom_range(0, 63));
            d        = $urandom;
            if (use_host) host_xfer(we, a, d, rd);
            else          init_xfer(we, a, d, rd);
            if (!we) check($sformatf("rand%0d_rd", i), rd, model_read(a));
            model_apply(we, a, d);
            check($sformatf("rand%0d_err", i), {31'b0, err}, {31'b0, model_err});
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
